memory_arbiter: RTL and testbench

Shares the single unified memory port between the CPU's instruction-fetch requester and its load/store requester. Requests are accepted, serialized one at a time, and answered back to the owner. Data accesses take priority, with a bounded starvation limit for fetch. A per-transaction timeout converts a hung memory into a sticky fault. It sits between `risc_v_cpu` (program counter / fetch and load/store unit) and the memory model.

---
 rtl/memory_arbiter_if.sv | 52 +++++
 rtl/memory_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side and memory-side signals around memory_arbiter.
// master = the arbiter itself, slave = the CPU requesters plus memory model.
interface memory_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        fault;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy, fault
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy, fault
    );
endinterface

// File: rtl/memory_arbiter.sv
// Serializes instruction-fetch and load/store requests onto one memory port,
// data first with bounded fetch starvation, and a timeout that latches a fault.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clock,
    input  logic              reset,
    memory_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIME_MAX   = TW'(TIMEOUT);

    state_t        state, state_next;
    owner_t        owner, owner_next;
    logic [SW-1:0] streak, streak_next;
    logic [TW-1:0] tcount, tcount_next;

    logic          mem_req_q,   mem_req_next;
    logic          mem_we_q,    mem_we_next;
    logic [3:0]    mem_be_q,    mem_be_next;
    logic [31:0]   mem_addr_q,  mem_addr_next;
    logic [31:0]   mem_wdata_q, mem_wdata_next;

    logic          if_rvalid_q, if_rvalid_next;
    logic [31:0]   if_rdata_q,  if_rdata_next;
    logic          if_err_q,    if_err_next;
    logic          d_rvalid_q,  d_rvalid_next;
    logic [31:0]   d_rdata_q,   d_rdata_next;
    logic          d_err_q,     d_err_next;

    logic          busy_q, busy_next;
    logic          fault_q, fault_next;

    logic          if_gnt_c, d_gnt_c;
    logic          data_wins;
    logic          timeout_hit;
    logic          resp_fire;
    logic          resp_err;
    logic [31:0]   resp_data;

    // Fetch only beats a pending data request once data has won STARVE_LIMIT times in a row.
    assign data_wins   = bus.d_req && (!bus.if_req || (streak != STREAK_MAX));
    assign timeout_hit = (TIMEOUT != 0) && ((tcount + TW'(1)) == TIME_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, grants and the next values of every registered output.
    always_comb begin
        state_next     = state;
        owner_next     = owner;
        streak_next    = streak;
        tcount_next    = tcount;
        mem_req_next   = mem_req_q;
        mem_we_next    = mem_we_q;
        mem_be_next    = mem_be_q;
        mem_addr_next  = mem_addr_q;
        mem_wdata_next = mem_wdata_q;
        fault_next     = fault_q;
        if_gnt_c       = 1'b0;
        d_gnt_c        = 1'b0;
        resp_fire      = 1'b0;
        resp_err       = 1'b0;
        resp_data      = 32'd0;

        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_next   = REQ;
                    tcount_next  = '0;
                    mem_req_next = 1'b1;
                    if (data_wins) begin
                        d_gnt_c        = 1'b1;
                        owner_next     = OWN_D;
                        mem_we_next    = bus.d_we;
                        mem_be_next    = bus.d_be;
                        mem_addr_next  = bus.d_addr;
                        mem_wdata_next = bus.d_wdata;
                        if (bus.if_req) begin
                            streak_next = (streak == STREAK_MAX) ? streak : streak + SW'(1);
                        end else begin
                            streak_next = '0;
                        end
                    end else begin
                        if_gnt_c       = 1'b1;
                        owner_next     = OWN_IF;
                        mem_we_next    = 1'b0;
                        mem_be_next    = 4'b1111;
                        mem_addr_next  = bus.if_addr;
                        mem_wdata_next = 32'd0;
                        streak_next    = '0;
                    end
                end
            end

            REQ: begin
                if (TIMEOUT != 0) begin
                    tcount_next = tcount + TW'(1);
                end
                if (timeout_hit) begin
                    state_next   = FAULT;
                    mem_req_next = 1'b0;
                    fault_next   = 1'b1;
                    resp_fire    = 1'b1;
                    resp_err     = 1'b1;
                end else if (bus.mem_gnt) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                end
            end

            RESP: begin
                if (TIMEOUT != 0) begin
                    tcount_next = tcount + TW'(1);
                end
                // A response arriving on the limit cycle still counts as a normal completion.
                if (bus.mem_rvalid) begin
                    state_next = IDLE;
                    resp_fire  = 1'b1;
                    resp_data  = bus.mem_rdata;
                end else if (timeout_hit) begin
                    state_next = FAULT;
                    fault_next = 1'b1;
                    resp_fire  = 1'b1;
                    resp_err   = 1'b1;
                end
            end

            FAULT: begin
                mem_req_next = 1'b0;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if_rvalid_next = resp_fire && (owner == OWN_IF);
        if_err_next    = resp_fire && (owner == OWN_IF) && resp_err;
        if_rdata_next  = (resp_fire && (owner == OWN_IF)) ? resp_data : 32'd0;
        d_rvalid_next  = resp_fire && (owner == OWN_D);
        d_err_next     = resp_fire && (owner == OWN_D) && resp_err;
        d_rdata_next   = (resp_fire && (owner == OWN_D)) ? resp_data : 32'd0;
        busy_next      = (state_next != IDLE);
    end

    // Datapath registers; a reset mid-transaction simply drops it.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= OWN_IF;
            streak      <= '0;
            tcount      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            owner       <= owner_next;
            streak      <= streak_next;
            tcount      <= tcount_next;
            mem_req_q   <= mem_req_next;
            mem_we_q    <= mem_we_next;
            mem_be_q    <= mem_be_next;
            mem_addr_q  <= mem_addr_next;
            mem_wdata_q <= mem_wdata_next;
            if_rvalid_q <= if_rvalid_next;
            if_rdata_q  <= if_rdata_next;
            if_err_q    <= if_err_next;
            d_rvalid_q  <= d_rvalid_next;
            d_rdata_q   <= d_rdata_next;
            d_err_q     <= d_err_next;
            busy_q      <= busy_next;
            fault_q     <= fault_next;
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, data priority, starvation,
// slow memory, reset mid-transaction and timeout fault.
module tb_memory_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    always #5 clock = ~clock;

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_be !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_mem_be: got %b want 0000", bus.mem_be); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fault: got %b want 0", bus.fault); end
        n_checks++; if ({bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_handshake: got %b want 0000", {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        bus.if_req = 1'b1;
        bus.if_addr = 32'd0;
        #1;
        n_checks++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_gnt: got if=%b d=%b want if=1 d=0", bus.if_gnt, bus.d_gnt); end
        tick();
        bus.if_req = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL fetch_mem_req: got req=%b addr=%h want 1/0", bus.mem_req, bus.mem_addr); end
        n_checks++; if (bus.mem_be !== 4'b1111 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'd0) begin n_fail++; $display("[TB] FAIL fetch_mem_fields: got be=%b we=%b wd=%h want 1111/0/0", bus.mem_be, bus.mem_we, bus.mem_wdata); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL fetch_busy: got %b want 1", bus.busy); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_req_drop: got %b want 0", bus.mem_req); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h0010_0310;
        tick();
        bus.mem_rvalid = 1'b0;
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0010_0310 || bus.if_err !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_resp: got v=%b d=%h e=%b want 1/00100310/0", bus.if_rvalid, bus.if_rdata, bus.if_err); end
        n_checks++; if (bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_idle: got d_rvalid=%b busy=%b want 0/0", bus.d_rvalid, bus.busy); end
        tick();
        n_checks++; if (bus.if_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_pulse: got %b want 0", bus.if_rvalid); end
    endtask

    task automatic test_simultaneous();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h80;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h40;
        bus.d_wdata = 32'd55;
        bus.d_be = 4'b1111;
        #1;
        n_checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_gnt: got d=%b if=%b want 1/0", bus.d_gnt, bus.if_gnt); end
        tick();
        bus.d_req = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'd55 || bus.mem_addr !== 32'h40) begin n_fail++; $display("[TB] FAIL sim_store: got we=%b wd=%0d a=%h want 1/55/40", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hDEAD;
        tick();
        bus.mem_rvalid = 1'b0;
        n_checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD || bus.if_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_store_resp: got dv=%b dd=%h iv=%b want 1/dead/0", bus.d_rvalid, bus.d_rdata, bus.if_rvalid); end
        #1;
        n_checks++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_fetch_gnt: got %b want 1", bus.if_gnt); end
        tick();
        bus.if_req = 1'b0;
        n_checks++; if (bus.mem_addr !== 32'h80 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'd0 || bus.mem_be !== 4'b1111) begin n_fail++; $display("[TB] FAIL sim_fetch_fields: got a=%h we=%b wd=%h be=%b want 80/0/0/1111", bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_be); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h1234;
        tick();
        bus.mem_rvalid = 1'b0;
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1234) begin n_fail++; $display("[TB] FAIL sim_fetch_resp: got v=%b d=%h want 1/1234", bus.if_rvalid, bus.if_rdata); end
        bus.d_we = 1'b0;
    endtask

    task automatic test_starvation();
        bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        bus.d_req = 1'b1;
        bus.d_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++; if (bus.d_gnt !== exp_d[i] || bus.if_gnt !== !exp_d[i]) begin n_fail++; $display("[TB] FAIL starve_order[%0d]: got d=%b if=%b want d=%b", i, bus.d_gnt, bus.if_gnt, exp_d[i]); end
            tick();
            bus.mem_gnt = 1'b1;
            tick();
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = 32'(i);
            tick();
            bus.mem_rvalid = 1'b0;
            n_checks++; if (bus.d_rvalid !== exp_d[i] || bus.if_rvalid !== !exp_d[i]) begin n_fail++; $display("[TB] FAIL starve_resp[%0d]: got dv=%b iv=%b want dv=%b", i, bus.d_rvalid, bus.if_rvalid, exp_d[i]); end
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_delayed_memory();
        int rv_count = 0;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_be = 4'b0011;
        bus.d_addr = 32'h300;
        #1;
        n_checks++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL slow_gnt: got %b want 1", bus.d_gnt); end
        tick();
        bus.d_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            bus.mem_gnt = (c == 4);
            bus.mem_rvalid = (c == 2);
            n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || bus.mem_be !== 4'b0011 || bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL slow_req_held[%0d]: got req=%b a=%h be=%b busy=%b want 1/300/0011/1", c, bus.mem_req, bus.mem_addr, bus.mem_be, bus.busy); end
            if (bus.d_rvalid) rv_count++;
            tick();
        end
        bus.mem_gnt = 1'b0;
        for (int c = 5; c <= 9; c++) begin
            bus.mem_rvalid = (c == 7);
            bus.mem_rdata = 32'hCAFE_0007;
            if (c <= 7) begin
                n_checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL slow_resp_wait[%0d]: got req=%b busy=%b want 0/1", c, bus.mem_req, bus.busy); end
            end
            if (bus.d_rvalid) begin
                rv_count++;
                n_checks++; if (c !== 8 || bus.d_rdata !== 32'hCAFE_0007) begin n_fail++; $display("[TB] FAIL slow_resp: got cycle=%0d data=%h want 8/cafe0007", c, bus.d_rdata); end
            end
            tick();
        end
        bus.mem_rvalid = 1'b0;
        n_checks++; if (rv_count !== 1) begin n_fail++; $display("[TB] FAIL slow_single_rvalid: got %0d want 1", rv_count); end
    endtask

    task automatic test_reset_in_resp();
        bus.d_req = 1'b1;
        bus.d_addr = 32'h400;
        tick();
        bus.d_req = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_idle: got busy=%b dv=%b req=%b want 0/0/0", bus.busy, bus.d_rvalid, bus.mem_req); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hBAD;
        tick();
        bus.mem_rvalid = 1'b0;
        n_checks++; if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_late_rvalid: got dv=%b iv=%b busy=%b want 0/0/0", bus.d_rvalid, bus.if_rvalid, bus.busy); end
    endtask

    task automatic test_timeout_fault();
        int rv_count = 0;
        int rv_cycle = -1;
        logic got_err = 1'b0;
        logic [31:0] got_data = 32'hFFFF_FFFF;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h500;
        tick();
        bus.if_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus.mem_gnt = (c == 1);
            if (bus.if_rvalid) begin
                rv_count++;
                rv_cycle = c;
                got_err = bus.if_err;
                got_data = bus.if_rdata;
            end
            tick();
        end
        bus.mem_gnt = 1'b0;
        n_checks++; if (rv_count !== 1) begin n_fail++; $display("[TB] FAIL tmo_rvalid_count: got %0d want 1", rv_count); end
        n_checks++; if (rv_cycle !== 17) begin n_fail++; $display("[TB] FAIL tmo_cycle: got %0d want 17", rv_cycle); end
        n_checks++; if (got_err !== 1'b1 || got_data !== 32'd0) begin n_fail++; $display("[TB] FAIL tmo_resp: got err=%b data=%h want 1/0", got_err, got_data); end
        n_checks++; if (bus.fault !== 1'b1 || bus.busy !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_fault_state: got fault=%b busy=%b req=%b want 1/1/0", bus.fault, bus.busy, bus.mem_req); end
        bus.if_req = 1'b1;
        bus.d_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_no_gnt[%0d]: got if=%b d=%b req=%b want 0/0/0", c, bus.if_gnt, bus.d_gnt, bus.mem_req); end
            tick();
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({bus.fault, bus.busy, bus.mem_req, bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.d_err} !== 7'b0) begin n_fail++; $display("[TB] FAIL tmo_reset_flags: got %b want 0000000", {bus.fault, bus.busy, bus.mem_req, bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.d_err}); end
        n_checks++; if (bus.mem_addr !== 32'd0 || bus.mem_be !== 4'd0 || bus.if_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL tmo_reset_data: got a=%h be=%b ird=%h drd=%h want all 0", bus.mem_addr, bus.mem_be, bus.if_rdata, bus.d_rdata); end
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = 32'd0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_be = 4'd0;
        bus.d_addr = 32'd0;
        bus.d_wdata = 32'd0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'd0;
        $display("[TB] starting memory_arbiter bench");
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_delayed_memory();
        test_reset_in_resp();
        test_timeout_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
